// File: rtl/ex_mc_pkg.sv
// Shared types and the result-slice helper for the EX-stage carry-less multiply controller.
package ex_mc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PLEN  = 64;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } mc_state_t;

    typedef enum logic [1:0] {
        MC_CLMUL  = 2'd0,
        MC_CLMULH = 2'd1,
        MC_CLMULR = 2'd2
    } mc_op_t;

    typedef struct packed {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } mc_req_t;

    // Reserved encoding 3 falls through to the CLMUL slice.
    function automatic logic [XLEN-1:0] mc_slice(input logic [1:0] op, input logic [PLEN-1:0] prod);
        case (op)
            MC_CLMULH: return prod[63:32];
            MC_CLMULR: return prod[62:31];
            default:   return prod[31:0];
        endcase
    endfunction

endpackage

// File: rtl/ex_mc_ctrl_if.sv
// EX-side request/result and unit-side handshake bundle for ex_mc_ctrl.
interface ex_mc_ctrl_if;
    import ex_mc_pkg::*;

    logic            ext_stall;
    logic            flush;
    logic            req_valid;
    logic [1:0]      req_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            stall_req;
    logic            res_valid;
    logic [XLEN-1:0] res;
    logic            timeout_trap;
    logic            unit_start;
    logic            unit_stall;
    logic [XLEN-1:0] unit_a;
    logic [XLEN-1:0] unit_b;
    logic            unit_eoc;
    logic [PLEN-1:0] unit_res;

    modport master (
        output ext_stall, flush, req_valid, req_op, op_a, op_b, unit_eoc, unit_res,
        input  stall_req, res_valid, res, timeout_trap, unit_start, unit_stall, unit_a, unit_b
    );

    modport slave (
        input  ext_stall, flush, req_valid, req_op, op_a, op_b, unit_eoc, unit_res,
        output stall_req, res_valid, res, timeout_trap, unit_start, unit_stall, unit_a, unit_b
    );

endinterface

// File: rtl/mc_result_cache.sv
// Single-entry operand/product store; invalidated only by reset.
module mc_result_cache
    import ex_mc_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_a,
    input  logic [XLEN-1:0] fill_b,
    input  logic [PLEN-1:0] fill_prod,
    input  logic [XLEN-1:0] look_a,
    input  logic [XLEN-1:0] look_b,
    output logic            match_c,
    output logic [PLEN-1:0] prod
);

    logic            valid;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            prod  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            a_q   <= fill_a;
            b_q   <= fill_b;
            prod  <= fill_prod;
        end
    end

    assign match_c = valid && (a_q == look_a) && (b_q == look_b);

endmodule

// File: rtl/ex_mc_ctrl.sv
// Sequencer for the iterative CLMUL unit: start pulse, pipeline stall, watchdog, result slice.
// Optional one-entry result cache enabled by defining MC_RESULT_CACHE_EN.
module ex_mc_ctrl
    import ex_mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    ex_mc_ctrl_if.slave  bus
);

    // Timeout fires when the counter would step onto TIMEOUT-1, i.e. TIMEOUT cycles after start.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    mc_state_t       state;
    mc_req_t         req_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] res_q;
    logic            trap_q;

    logic            hit_c;
    logic [XLEN-1:0] hit_res_c;
    logic            accept_c;

`ifdef MC_RESULT_CACHE_EN
    logic            fill_c;
    logic            match_c;
    logic [PLEN-1:0] cache_prod;

    assign fill_c = reset_n && (state == RUN) && !bus.flush && !bus.ext_stall && bus.unit_eoc;

    mc_result_cache u_cache (
        .clk       (clk),
        .reset_n   (reset_n),
        .fill      (fill_c),
        .fill_a    (req_q.a),
        .fill_b    (req_q.b),
        .fill_prod (bus.unit_res),
        .look_a    (bus.op_a),
        .look_b    (bus.op_b),
        .match_c   (match_c),
        .prod      (cache_prod)
    );

    assign hit_c     = reset_n && (state == IDLE) && bus.req_valid && !bus.flush && match_c;
    assign hit_res_c = mc_slice(bus.req_op, cache_prod);
`else
    assign hit_c     = 1'b0;
    assign hit_res_c = '0;
`endif

    assign accept_c = reset_n && (state == IDLE) && bus.req_valid && !bus.ext_stall
                      && !bus.flush && !hit_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            req_q  <= '0;
            cnt    <= '0;
            res_q  <= '0;
            trap_q <= 1'b0;
        end else begin
            trap_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        req_q <= '{op: bus.req_op, a: bus.op_a, b: bus.op_b};
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (!bus.ext_stall) begin
                        if (bus.unit_eoc) begin
                            res_q <= mc_slice(req_q.op, bus.unit_res);
                            state <= HOLD;
                        end else if (cnt == CNT_LAST) begin
                            res_q  <= '0;
                            trap_q <= 1'b1;
                            state  <= HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.flush || !bus.ext_stall) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall_req    = reset_n && bus.req_valid && !bus.flush && (state != HOLD) && !hit_c;
    assign bus.res_valid    = (reset_n && (state == HOLD)) || hit_c;
    assign bus.res          = hit_c ? hit_res_c : res_q;
    assign bus.timeout_trap = trap_q;
    assign bus.unit_start   = accept_c;
    assign bus.unit_stall   = reset_n && (state == RUN) && bus.ext_stall;
    assign bus.unit_a       = !reset_n ? '0 : ((state == IDLE) ? bus.op_a : req_q.a);
    assign bus.unit_b       = !reset_n ? '0 : ((state == IDLE) ? bus.op_b : req_q.b);

endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Self-checking bench for ex_mc_ctrl; the bench plays both the EX stage and the iterative unit.
module tb_ex_mc_ctrl;
    import ex_mc_pkg::*;

    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic reset_n;

    ex_mc_ctrl_if bus ();

    ex_mc_ctrl #(.TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;

    always @(posedge clk) if (bus.unit_start === 1'b1) n_start <= n_start + 1;

    // Reference state: last registered result and the expected cache contents.
    logic [31:0] last_res;
    bit          mc_v;
    logic [31:0] mc_a, mc_b;
    logic [63:0] mc_p;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) if (b[i]) p ^= ({32'h0, a} << i);
        return p;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] op, input logic [63:0] p);
        logic [63:0] s;
        s = (op == 2'd1) ? (p >> 32) : (op == 2'd2) ? (p >> 31) : p;
        return s[31:0];
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive_idle();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.ext_stall = 1'b0;
        bus.unit_eoc  = 1'b0;
        bus.req_op    = 2'($urandom_range(0, 3));
        bus.op_a      = $urandom;
        bus.op_b      = $urandom;
        bus.unit_res  = rnd64();
    endtask

    // Drive the accepting cycle and check the miss-path T0 behaviour.
    task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        @(negedge clk);
        drive_idle();
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.op_a      = a;
        bus.op_b      = b;
        #1;
        check("t0_trap", bus.timeout_trap, 0);
        check("t0_stall", bus.stall_req, 1);
        check("t0_start", bus.unit_start, 1);
        check("t0_unit_a", bus.unit_a, a);
        check("t0_unit_b", bus.unit_b, b);
        check("t0_valid", bus.res_valid, 0);
    endtask

    // Full request: eoc after k unstalled RUN cycles, ext_stall window [s0, s0+slen), hlen HOLD stalls.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input int k, input int s0, input int slen, input int hlen);
        logic [63:0] p;
        logic [31:0] exp;
        int act, st0;
        bit stl;
        p   = clmul(a, b);
        exp = pick(op, p);
        st0 = n_start;
`ifdef MC_RESULT_CACHE_EN
        if (mc_v && mc_a == a && mc_b == b) begin
            @(negedge clk);
            drive_idle();
            bus.req_valid = 1'b1;
            bus.req_op    = op;
            bus.op_a      = a;
            bus.op_b      = b;
            #1;
            check("hit_valid", bus.res_valid, 1);
            check("hit_res", bus.res, pick(op, mc_p));
            check("hit_stall", bus.stall_req, 0);
            check("hit_start", bus.unit_start, 0);
            return;
        end
`endif
        start_req(a, b, op);
        act = 0;
        for (int c = 1; c <= k + slen; c++) begin
            @(negedge clk);
            stl = (slen > 0) && (c >= s0) && (c < s0 + slen);
            if (!stl) act++;
            bus.ext_stall = stl;
            bus.op_a      = ~a;
            bus.op_b      = ~b;
            bus.unit_eoc  = !stl && (act == k);
            bus.unit_res  = bus.unit_eoc ? p : rnd64();
            #1;
            check("run_stall", bus.stall_req, 1);
            check("run_unit_stall", bus.unit_stall, 64'(stl));
            check("run_valid", bus.res_valid, 0);
            check("run_trap", bus.timeout_trap, 0);
            check("run_unit_a", bus.unit_a, a);
            check("run_unit_b", bus.unit_b, b);
        end
        last_res = exp;
        mc_v = 1'b1; mc_a = a; mc_b = b; mc_p = p;
        for (int h = 0; h <= hlen; h++) begin
            @(negedge clk);
            bus.op_a      = a;
            bus.op_b      = b;
            bus.unit_eoc  = 1'b0;
            bus.unit_res  = rnd64();
            bus.ext_stall = (h < hlen);
            #1;
            check("hold_valid", bus.res_valid, 1);
            check("hold_res", bus.res, exp);
            check("hold_stall", bus.stall_req, 0);
        end
        check("start_count", 64'(n_start - st0), 1);
    endtask

    task automatic make_fresh(inout logic [31:0] a, input logic [31:0] b);
`ifdef MC_RESULT_CACHE_EN
        while (mc_v && a == mc_a && b == mc_b) a = a + 32'd1;
`endif
    endtask

    task automatic do_timeout(input logic [31:0] a_in, input logic [31:0] b, input logic [1:0] op);
        logic [31:0] a;
        int st0;
        a = a_in;
        make_fresh(a, b);
        st0 = n_start;
        start_req(a, b, op);
        for (int c = 1; c <= int'(TMO); c++) begin
            @(negedge clk);
            bus.unit_eoc = 1'b0;
            bus.unit_res = rnd64();
            #1;
            check("wd_trap", bus.timeout_trap, 64'(c == int'(TMO)));
            check("wd_stall", bus.stall_req, 64'(c < int'(TMO)));
            check("wd_valid", bus.res_valid, 64'(c == int'(TMO)));
            if (c == int'(TMO)) check("wd_res", bus.res, 0);
        end
        last_res = '0;
        check("wd_start_count", 64'(n_start - st0), 1);
    endtask

    task automatic do_flush(input logic [31:0] a_in, input logic [31:0] b, input int k);
        logic [31:0] a;
        int st0;
        a = a_in;
        make_fresh(a, b);
        st0 = n_start;
        start_req(a, b, 2'd0);
        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            bus.unit_eoc = (c == k);
            bus.flush    = (c == k);
            bus.unit_res = clmul(a, b);
            #1;
            check("fl_stall", bus.stall_req, 64'(c < k));
        end
        @(negedge clk);
        drive_idle();
        #1;
        check("fl_valid", bus.res_valid, 0);
        check("fl_res", bus.res, last_res);
        check("fl_stall_after", bus.stall_req, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        bus.op_a      = a;
        bus.op_b      = b;
        #1;
        check("fl_idle_start", bus.unit_start, 0);
        check("fl_idle_stall", bus.stall_req, 0);
        @(negedge clk);
        drive_idle();
        #1;
        check("fl_idle_state", bus.res_valid, 0);
        check("fl_start_count", 64'(n_start - st0), 1);
    endtask

    task automatic do_reset_mid_run(input logic [31:0] a, input logic [31:0] b);
        start_req(a, b, 2'd1);
        repeat (2) begin
            @(negedge clk);
            bus.unit_eoc = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_stall", bus.stall_req, 0);
        check("rst_start", bus.unit_start, 0);
        check("rst_unit_a", bus.unit_a, 0);
        check("rst_valid", bus.res_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive_idle();
        mc_v = 1'b0;
        last_res = '0;
        #1;
        check("rst_res", bus.res, 0);
        for (int c = 0; c < int'(TMO) + 2; c++) begin
            @(negedge clk);
            drive_idle();
            #1;
            check("rst_no_trap", bus.timeout_trap, 0);
            check("rst_idle_valid", bus.res_valid, 0);
        end
    endtask

    initial begin
        int k, s0, slen, hlen, kind;
        logic [31:0] pool [4];
        drive_idle();
        bus.req_valid = 1'b1;
        reset_n  = 1'b0;
        mc_v     = 1'b0;
        last_res = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_res", bus.res, 0);
        check("reset_valid", bus.res_valid, 0);
        check("reset_stall", bus.stall_req, 0);
        check("reset_trap", bus.timeout_trap, 0);
        check("reset_start", bus.unit_start, 0);
        check("reset_unit_stall", bus.unit_stall, 0);
        check("reset_unit_a", bus.unit_a, 0);
        check("reset_unit_b", bus.unit_b, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive_idle();

        do_req(32'h8000_0001, 32'h3, 2'd0, 3, 0, 0, 0);
        do_req(32'h8000_0001, 32'h3, 2'd0, 3, 0, 0, 0);
        do_req(32'h8000_0001, 32'h5, 2'd0, 3, 0, 0, 0);
        do_req(32'h8000_0001, 32'h3, 2'd1, 3, 0, 0, 0);
        do_req(32'h8000_0001, 32'h3, 2'd2, 3, 0, 0, 0);
        do_req(32'h8000_0001, 32'h3, 2'd3, 3, 0, 0, 0);
        do_req($urandom, $urandom, 2'd0, 6, 2, 5, 2);
        do_req($urandom, $urandom, 2'd2, 1, 0, 0, 0);
        do_req($urandom, $urandom, 2'd1, int'(TMO) - 1, 0, 0, 1);
        do_timeout($urandom, $urandom, 2'd0);
        do_flush($urandom, $urandom, 2);
        do_req($urandom, $urandom, 2'd0, 2, 0, 0, 0);
        do_reset_mid_run($urandom, $urandom);

        for (int i = 0; i < 4; i++) pool[i] = $urandom;
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            k    = int'($urandom_range(1, TMO - 1));
            s0   = int'($urandom_range(1, k));
            slen = int'($urandom_range(0, 4));
            hlen = int'($urandom_range(0, 2));
            if (kind == 0) do_timeout(pool[$urandom_range(0, 3)], $urandom, 2'($urandom_range(0, 3)));
            else if (kind == 1) do_flush($urandom, $urandom, k);
            else do_req(pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                        2'($urandom_range(0, 3)), k, s0, slen, hlen);
        end

        @(negedge clk);
        drive_idle();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mc_ctrl.md
# ex_mc_ctrl

Sequencing controller for the multi-cycle carry-less multiply unit used by the EX stage. It accepts a CLMUL/CLMULH/CLMULR request from EX and issues a single start pulse to the iterative unit. It holds the pipeline stalled until end-of-computation, then selects and registers the 32-bit result slice. It also guards the unit with a cycle watchdog and honours external stalls and pipeline flushes.

## Interface
- TIMEOUT, 64: maximum RUN cycles without `unit_eoc` before the watchdog trap fires; legal range 2..255.
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- ext_stall  in  1  pipeline frozen by a downstream or memory stall
- flush  in  1  the EX instruction is squashed
- req_valid  in  1  the EX instruction is a carry-less multiply op
- req_op  in  2  0=CLMUL, 1=CLMULH, 2=CLMULR, 3=reserved (treated as CLMUL)
- op_a, op_b  in  32  source operands
- stall_req  out  1  stall request to hazard logic
- res_valid  out  1  `res` is valid for the current EX instruction
- res  out  32  selected result slice
- timeout_trap  out  1  one-cycle pulse when the watchdog expires
- unit_start  out  1  start pulse to the unit
- unit_stall  out  1  freeze to the unit
- unit_a, unit_b  out  32  unit operands
- unit_eoc  in  1  unit end-of-computation
- unit_res  in  64  full unit product

## Operation
- FSM states: IDLE, RUN, HOLD.
- **IDLE**
  - If `req_valid && !ext_stall && !flush`: pulse `unit_start`, latch `op_a`, `op_b` and `req_op`, clear the cycle counter, go to RUN.
  - `unit_a`/`unit_b` = `op_a`/`op_b` while in IDLE; otherwise they drive the latched values.
- **RUN**
  - `ext_stall`: `unit_stall`=1 and the counter is frozen.
  - Otherwise the counter increments.
  - `unit_eoc` (sampled only when `!ext_stall`): register the slice into `res` and go to HOLD.
  - Counter reaches TIMEOUT-1 without `unit_eoc`: `res`=0, pulse `timeout_trap`, go to HOLD.
- **HOLD**
  - `res_valid`=1.
  - `!ext_stall` → IDLE (the EX instruction advances); `ext_stall` → stay in HOLD.
- Slice selection:
  - CLMUL = `unit_res[31:0]`
  - CLMULH = `unit_res[63:32]`
  - CLMULR = `unit_res[62:31]`
- `stall_req = req_valid && !flush && (state != HOLD)`, with the cache-hit exception below.
- `flush` in any state: next state is IDLE and no `unit_start` is issued. An in-flight unit operation is abandoned, because the unit restarts on its next `unit_start`.
- `flush` and `unit_eoc` in the same cycle: `flush` wins; `res` is not updated.
- Reset:
  - State = IDLE; counter = 0.
  - Outputs `res`, `res_valid`, `stall_req`, `timeout_trap`, `unit_start`, `unit_stall` are all 0.
  - `unit_a`, `unit_b` = 0 and latched `req_op` = 0.
- Reset mid-RUN returns to IDLE on the next edge; no trap is raised.

## Timing
- Request accepted at cycle T0 (`unit_start` high, `stall_req` high).
- `unit_eoc` at cycle Tk → `res_valid` at Tk+1, with `stall_req` low at Tk+1.
- `stall_req` is high from T0 through Tk.
- Minimum miss latency is 2 cycles (eoc at T1).
- Back-to-back requests: a new request in the cycle after HOLD exits is accepted in IDLE with no bubble.
- `timeout_trap` is asserted exactly one cycle, the cycle HOLD is entered.

## Configuration
- **MC_RESULT_CACHE_EN defined:** a one-entry cache holds {`a`, `b`, 64-bit product, valid}.
  - Filled on every `unit_eoc` capture; timeout results are never cached.
  - Invalidated only by reset.
  - In IDLE, `req_valid` with `op_a`/`op_b` matching a valid entry is a hit:
    - `res_valid`=1 combinationally, with `res` = slice of the cached product.
    - `stall_req`=0, no `unit_start`, state stays IDLE.
- **MC_RESULT_CACHE_EN undefined:** there is no cache; every request takes the RUN path.

## Structure
- Package `ex_mc_pkg` holds:
  - the `mc_state_t` enum (IDLE/RUN/HOLD);
  - the `mc_op_t` enum (MC_CLMUL/MC_CLMULH/MC_CLMULR);
  - function `mc_slice(op, prod64)`.
- Sub-module `mc_result_cache`: single-entry store with compare, instantiated only under MC_RESULT_CACHE_EN.

## Test plan
- **CLMUL, eoc after 3 cycles.** Stimulus: `op_a`=0x80000001, `op_b`=0x3, `req_op`=0, `unit_res`=0x0000_0001_8000_0003. Response: `stall_req` high for T0..T3, `res`=0x80000003 with `res_valid` at T4, exactly one `unit_start`.
- **CLMULH / CLMULR.** Same operands and product. Response: `res`=0x00000001 for CLMULH and 0x00000003 for CLMULR.
- **ext_stall in RUN, then in HOLD.** Stimulus: `ext_stall` held 5 cycles mid-RUN, then 2 cycles in HOLD. Response: `unit_stall` mirrors `ext_stall`, the counter is frozen, `res_valid` is held through the HOLD stall, and IDLE is entered after the stall drops.
- **Watchdog, TIMEOUT=8.** Stimulus: `unit_eoc` never asserted. Response: single `timeout_trap` pulse 8 cycles after `unit_start`, `res`=0.
- **Flush.** Stimulus: `flush` asserted in RUN coincident with `unit_eoc`. Response: IDLE next cycle, `res` unchanged, no `res_valid`. A following request restarts with a new `unit_start`.
- **Cache hit (MC_RESULT_CACHE_EN).** Stimulus: repeat the first scenario's operands. Response: `res_valid` in the same cycle, `stall_req`=0, no `unit_start`. Changing `op_b` to 0x5 forces a miss.
